// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the front end: word width, canonical NOP and the
// {pc, instr} pair that travels from fetch to decode.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and clear. Pointers wrap by explicit
// compare so DEPTH need not be a power of two. Head data is read combinationally.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pointer and occupancy bookkeeping; clear behaves like reset.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !rst && !clear) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch-to-decode buffer. Holds the PC issued to instruction memory for one
// cycle, pairs it with the returning word and queues the pair for decode.
// Credit for a new PC counts the in-flight slot but never a same-cycle pop,
// so in_ready has no combinational dependency on out_ready.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN      = riscv_pkg::XLEN,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    output logic            in_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    input  logic            out_ready
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    logic            pend_valid;
    logic [XLEN-1:0] pend_pc;
    logic            accept;
    logic            push;
    logic            pop;
    logic            credit;
    logic [CW-1:0]   count;
    if_entry_t       wr_entry;
    if_entry_t       head;

    assign credit   = ({1'b0, count} + {{CW{1'b0}}, pend_valid}) < (CW+1)'(DEPTH);
    assign in_ready = ~flush & credit;
    assign accept   = in_valid & in_ready;

    // The word returning during a flush cycle belongs to a squashed PC.
    assign push      = pend_valid & ~flush;
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready & ~flush;

    // Pair the pending PC with the word memory returns this cycle.
    always_comb begin
        wr_entry.pc    = pend_pc;
        wr_entry.instr = imem_rdata;
    end

    // One-entry stage tracking the PC whose memory read is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else if (flush) begin
            pend_valid <= 1'b0;
        end else begin
            pend_valid <= accept;
            if (accept) pend_pc <= in_pc;
        end
    end

    sync_fifo #(
        .WIDTH($bits(if_entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .clear(flush),
        .push (push),
        .pop  (pop),
        .wdata(wr_entry),
        .rdata(head),
        .count(count)
    );

    // Empty queue presents a bubble rather than stale storage.
    always_comb begin
        out_pc    = out_valid ? head.pc    : '0;
        out_instr = out_valid ? head.instr : NOP_INSTR;
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: a DEPTH=4 and a DEPTH=3 instance share stimulus, each
// checked every cycle against a queue-based model of the buffer's contract.
module tb_fetch_buffer;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] imem_rdata;
    logic        out_ready;
    logic        rdy [2];
    logic        ov  [2];
    logic [31:0] opc [2];
    logic [31:0] oins[2];

    int total = 0;
    int bad   = 0;

    // Model state: queued pairs plus the one PC whose memory read is in flight.
    if_entry_t   q0[$];
    if_entry_t   q1[$];
    bit          inf_v [2];
    logic [31:0] inf_pc[2];
    bit          acc   [2];
    logic [31:0] last_addr;
    int          t2_acc;

    fetch_buffer #(.DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
        .in_ready(rdy[0]), .imem_rdata(imem_rdata), .out_valid(ov[0]), .out_pc(opc[0]),
        .out_instr(oins[0]), .out_ready(out_ready)
    );

    fetch_buffer #(.DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
        .in_ready(rdy[1]), .imem_rdata(imem_rdata), .out_valid(ov[1]), .out_pc(opc[1]),
        .out_instr(oins[1]), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents as a fixed function of the address.
    function automatic logic [31:0] imem_f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5a5a_c3c3;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, compare both instances with the model, advance the model.
    task automatic cycle(input bit rs, input bit fl, input bit iv, input logic [31:0] pc,
                         input bit ordy);
        if_entry_t   q[$];
        int          depth;
        bit          er;
        logic [31:0] epc;
        logic [31:0] ein;
        @(negedge clk);
        rst        = rs;
        flush      = fl;
        in_valid   = iv;
        in_pc      = pc;
        out_ready  = ordy;
        imem_rdata = imem_f(last_addr);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) q = q0; else q = q1;
            depth = (k == 0) ? 4 : 3;
            er  = !fl && ((q.size() + int'(inf_v[k])) < depth);
            epc = (q.size() != 0) ? q[0].pc : 32'h0;
            ein = (q.size() != 0) ? q[0].instr : 32'h0000_0013;
            check_eq($sformatf("d%0d_in_ready", k), 64'(rdy[k]), 64'(er));
            check_eq($sformatf("d%0d_out_valid", k), 64'(ov[k]), 64'(q.size() != 0));
            check_eq($sformatf("d%0d_out_pc", k), 64'(opc[k]), 64'(epc));
            check_eq($sformatf("d%0d_out_instr", k), 64'(oins[k]), 64'(ein));
            acc[k] = iv && er;
        end
        if (iv && rdy[0] && !rs) t2_acc++;
        @(posedge clk);
        last_addr = pc;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) q = q0; else q = q1;
            if (rs || fl) begin
                q.delete();
                inf_v[k] = 1'b0;
            end else begin
                if (q.size() != 0 && ordy) void'(q.pop_front());
                if (inf_v[k]) q.push_back('{pc: inf_pc[k], instr: imem_f(inf_pc[k])});
                inf_v[k] = acc[k];
                if (acc[k]) inf_pc[k] = pc;
            end
            if (k == 0) q0 = q; else q1 = q;
        end
    endtask

    initial begin
        logic [31:0] pc;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; out_ready = 1'b0;
        imem_rdata = '0; last_addr = '0; t2_acc = 0;
        inf_v[0] = 1'b0; inf_v[1] = 1'b0; inf_pc[0] = '0; inf_pc[1] = '0;

        repeat (2) cycle(1, 0, 0, 32'h0, 0);

        // Back-to-back fetch of 0,4,8,12 with decode always ready.
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 32'(4 * i), 1);
        repeat (4) cycle(0, 0, 0, 32'h0, 1);

        // Decode stalled: buffer takes exactly DEPTH PCs, then drains in order.
        t2_acc = 0;
        for (int i = 0; i < 7; i++) cycle(0, 0, 1, 32'h40 + 32'(4 * i), 0);
        check_eq("t2_accepts", 64'(t2_acc), 64'd4);
        repeat (6) cycle(0, 0, 0, 32'h0, 1);

        // Flush with entries queued and one in flight; only post-flush PC survives.
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 32'h80 + 32'(4 * i), 0);
        cycle(0, 1, 1, 32'h90, 0);
        cycle(0, 0, 1, 32'h100, 1);
        repeat (4) cycle(0, 0, 0, 32'h0, 1);

        // Accept attempt in the flush cycle must be refused.
        cycle(0, 1, 1, 32'h20, 1);
        repeat (3) cycle(0, 0, 0, 32'h0, 1);

        // Steady push+pop with a pre-filled queue; pointers wrap repeatedly.
        for (int i = 0; i < 2; i++) cycle(0, 0, 1, 32'h200 + 32'(4 * i), 0);
        for (int i = 0; i < 12; i++) cycle(0, 0, 1, 32'h300 + 32'(4 * i), 1);
        repeat (5) cycle(0, 0, 0, 32'h0, 1);

        // Reset with two queued and one in flight.
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 32'h400 + 32'(4 * i), 0);
        cycle(1, 0, 1, 32'h40c, 1);
        repeat (3) cycle(0, 0, 0, 32'h0, 1);

        // Random traffic.
        pc = 32'h1000;
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) != 0), pc, ($urandom_range(0, 2) != 0));
            pc = pc + 32'(4 * $urandom_range(1, 3));
        end
        repeat (6) cycle(0, 0, 0, 32'h0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
